// File: rtl/rv32i_pkg.sv
// Shared encodings and helpers for the RV32I pipeline control blocks.
// Holds the hazard FSM states, the operand-forwarding select codes and a register-match helper.
package rv32i_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    MWAIT = 2'b01,
    ERR   = 2'b10
  } hz_state_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  // A producer matches a consumer only if it writes a real register; x0 never matches.
  function automatic logic reg_hit(input logic wr, input logic [4:0] rd, input logic [4:0] rs);
    return wr && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/fwd_sel.sv
// Operand forwarding select for one EX-stage source register.
// The younger MEM result wins over the older WB result.
module fwd_sel
  import rv32i_pkg::*;
(
  input  logic [4:0] i_mem_rd,
  input  logic       i_mem_wr,
  input  logic [4:0] i_wb_rd,
  input  logic       i_wb_wr,
  input  logic [4:0] i_ex_rs,
  output logic [1:0] o_fwd
);

  fwd_sel_e w_sel;

  // NOTE: w_sel gets its default before any branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_sel = FWD_RF;
    if (reg_hit(i_mem_wr, i_mem_rd, i_ex_rs)) begin
      w_sel = FWD_MEM;
    end else if (reg_hit(i_wb_wr, i_wb_rd, i_ex_rs)) begin
      w_sel = FWD_WB;
    end
  end

  assign o_fwd = w_sel;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: dmem-wait freeze with timeout, redirect flush,
// load-use interlock, operand forwarding selects and stall/flush performance counters.
module hazard_ctrl
  import rv32i_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic [4:0]       mem_rd,
  input  logic [4:0]       wb_rd,
  input  logic             ex_wr,
  input  logic             mem_wr,
  input  logic             wb_wr,
  input  logic             ex_is_load,
  input  logic             ex_redirect,
  input  logic             dmem_req,
  input  logic             dmem_ack,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             stall_mem,
  output logic             flush_id,
  output logic             bubble_ex,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             err
);

  localparam int                WAIT_W    = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  hz_state_e         r_state;
  hz_state_e         w_state_nxt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_nxt;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;
  logic              w_load_use;
  logic              w_freeze;
  logic              w_front_stall;
  logic              w_flush;
  logic              w_bubble;
  logic              w_any_stall;

  assign w_load_use = ex_is_load &&
                      ((id_use_rs1 && reg_hit(ex_wr, ex_rd, id_rs1)) ||
                       (id_use_rs2 && reg_hit(ex_wr, ex_rd, id_rs2)));

  // Priority inside RUN: dmem freeze, then redirect, then load-use.
  always_comb begin
    w_state_nxt   = r_state;
    w_wait_nxt    = r_wait_cnt;
    w_freeze      = 1'b0;
    w_front_stall = 1'b0;
    w_flush       = 1'b0;
    w_bubble      = 1'b0;
    case (r_state)
      RUN: begin
        if (dmem_req && !dmem_ack) begin
          w_freeze    = 1'b1;
          w_state_nxt = MWAIT;
          w_wait_nxt  = '0;
        end else if (ex_redirect) begin
          w_flush  = 1'b1;
          w_bubble = 1'b1;
        end else if (w_load_use) begin
          w_front_stall = 1'b1;
          w_bubble      = 1'b1;
        end
      end
      MWAIT: begin
        if (dmem_ack) begin
          w_state_nxt = RUN;
        end else begin
          w_freeze = 1'b1;
          if (r_wait_cnt == WAIT_LAST) begin
            w_state_nxt = ERR;
          end else begin
            w_wait_nxt = r_wait_cnt + WAIT_W'(1);
          end
        end
      end
      ERR:     w_freeze = 1'b1;
      default: w_state_nxt = RUN;
    endcase
  end

  // Control outputs are forced low while reset is held, whatever the inputs do.
  assign stall_if    = rst & (w_freeze | w_front_stall);
  assign stall_id    = rst & (w_freeze | w_front_stall);
  assign stall_ex    = rst & w_freeze;
  assign stall_mem   = rst & w_freeze;
  assign flush_id    = rst & w_flush;
  assign bubble_ex   = rst & w_bubble;
  assign w_any_stall = stall_if | stall_id | stall_ex | stall_mem;
  assign err         = (r_state == ERR);

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= RUN;
      r_wait_cnt  <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      if (w_any_stall) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (flush_id)    r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

  fwd_sel u_fwd_a (
    .i_mem_rd (mem_rd),
    .i_mem_wr (mem_wr),
    .i_wb_rd  (wb_rd),
    .i_wb_wr  (wb_wr),
    .i_ex_rs  (ex_rs1),
    .o_fwd    (fwd_a)
  );

  fwd_sel u_fwd_b (
    .i_mem_rd (mem_rd),
    .i_mem_wr (mem_wr),
    .i_wb_rd  (wb_rd),
    .i_wb_wr  (wb_wr),
    .i_ex_rs  (ex_rs2),
    .o_fwd    (fwd_b)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic
// compared against a behavioural model of the hazard rules.
module tb_hazard_ctrl;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic             id_use_rs1, id_use_rs2, ex_wr, mem_wr, wb_wr;
  logic             ex_is_load, ex_redirect, dmem_req, dmem_ack;
  logic             stall_if, stall_id, stall_ex, stall_mem, flush_id, bubble_ex, err;
  logic [1:0]       fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  // Model: waiting / errored flags, MWAIT cycle count, and unbounded event counts.
  bit          m_waiting, m_error;
  int          m_wait_cycles, m_stall_cnt, m_flush_cnt;
  logic        e_sif, e_sid, e_sex, e_smem, e_flush, e_bub, e_err;
  logic [1:0]  e_fa, e_fb;
  logic [18:0] e_vec;

  hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .ex_wr(ex_wr), .mem_wr(mem_wr), .wb_wr(wb_wr), .ex_is_load(ex_is_load),
    .ex_redirect(ex_redirect), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
    .flush_id(flush_id), .bubble_ex(bubble_ex), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
    if (rs == 5'd0) return 2'b00;
    if (mem_wr && mem_rd == rs) return 2'b01;
    if (wb_wr && wb_rd == rs) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [18:0] obs_vec();
    return {stall_if, stall_id, stall_ex, stall_mem, flush_id, bubble_ex,
            fwd_a, fwd_b, err, stall_cnt, flush_cnt};
  endfunction

  task automatic m_reset();
    m_waiting = 0; m_error = 0; m_wait_cycles = 0; m_stall_cnt = 0; m_flush_cnt = 0;
  endtask

  task automatic set_idle();
    {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
    {id_use_rs1, id_use_rs2, ex_wr, mem_wr, wb_wr} = '0;
    {ex_is_load, ex_redirect, dmem_req, dmem_ack} = '0;
  endtask

  task automatic rand_inputs();
    id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
    ex_rs1 = 5'($urandom_range(0, 3)); ex_rs2 = 5'($urandom_range(0, 3));
    ex_rd  = 5'($urandom_range(0, 3)); mem_rd = 5'($urandom_range(0, 3));
    wb_rd  = 5'($urandom_range(0, 3));
    id_use_rs1 = 1'($urandom); id_use_rs2 = 1'($urandom);
    ex_wr  = 1'($urandom); mem_wr = 1'($urandom); wb_wr = 1'($urandom);
    ex_is_load  = 1'($urandom);
    ex_redirect = ($urandom_range(0, 3) == 0);
    dmem_req    = ($urandom_range(0, 3) == 0);
    dmem_ack    = ($urandom_range(0, 9) < 3);
  endtask

  // Waits for the falling edge and derives the expected outputs from the hazard rules.
  task automatic sample();
    logic freeze, run_free, lu;
    @(negedge clk);
    lu = ex_is_load && ex_wr && ex_rd != 5'd0 &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    if (m_error)        freeze = 1'b1;
    else if (m_waiting) freeze = !dmem_ack;
    else                freeze = dmem_req && !dmem_ack;
    run_free = !m_error && !m_waiting && !freeze;
    e_sex   = rst && freeze;
    e_smem  = rst && freeze;
    e_flush = rst && run_free && ex_redirect;
    e_sif   = rst && (freeze || (run_free && !ex_redirect && lu));
    e_sid   = e_sif;
    e_bub   = e_flush || (rst && run_free && !ex_redirect && lu);
    e_err   = m_error;
    e_fa    = fwd_ref(ex_rs1);
    e_fb    = fwd_ref(ex_rs2);
    e_vec   = {e_sif, e_sid, e_sex, e_smem, e_flush, e_bub, e_fa, e_fb, e_err,
               m_stall_cnt[3:0], m_flush_cnt[3:0]};
  endtask

  // Rising edge: advance the model exactly as the rules describe, then step off the edge.
  task automatic advance();
    @(posedge clk);
    if (rst) begin
      if (e_sif || e_sid || e_sex || e_smem) m_stall_cnt++;
      if (e_flush) m_flush_cnt++;
      if (m_error) begin
      end else if (m_waiting) begin
        if (dmem_ack) m_waiting = 0;
        else begin
          m_wait_cycles++;
          if (m_wait_cycles == TIMEOUT) begin m_error = 1; m_waiting = 0; end
        end
      end else if (dmem_req && !dmem_ack) begin
        m_waiting = 1; m_wait_cycles = 0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rand_inputs();
    ex_redirect = 1'b1; dmem_req = 1'b1; dmem_ack = 1'b0;
    m_reset();
    for (int i = 0; i < 2; i++) begin
      sample();
      checks++;
      if (obs_vec() !== e_vec) begin
        errors++; $display("FAIL reset_model got=%h exp=%h", obs_vec(), e_vec);
      end
      checks++;
      if ({stall_if, stall_id, stall_ex, stall_mem, flush_id, bubble_ex, err, stall_cnt, flush_cnt} !== 15'd0) begin
        errors++; $display("FAIL reset_outputs got=%b exp=0", {stall_if, stall_id, stall_ex, stall_mem, flush_id, bubble_ex, err});
      end
      advance();
    end
    rst = 1'b1;
    set_idle();
  endtask

  task automatic test_load_use();
    int s0;
    set_idle();
    ex_is_load = 1; ex_wr = 1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1;
    s0 = m_stall_cnt;
    sample();
    checks++;
    if (obs_vec() !== e_vec) begin errors++; $display("FAIL load_use_model got=%h exp=%h", obs_vec(), e_vec); end
    checks++;
    if ({stall_if, stall_id, bubble_ex, stall_ex, stall_mem, flush_id} !== 6'b111000) begin
      errors++; $display("FAIL load_use_outs got=%b exp=111000", {stall_if, stall_id, bubble_ex, stall_ex, stall_mem, flush_id});
    end
    advance();
    set_idle();
    ex_is_load = 1; ex_wr = 1; id_use_rs1 = 1;
    sample();
    checks++;
    if ({stall_if, bubble_ex} !== 2'b00) begin
      errors++; $display("FAIL load_use_x0 got=%b exp=00", {stall_if, bubble_ex});
    end
    checks++;
    if (stall_cnt !== 4'(s0 + 1)) begin
      errors++; $display("FAIL load_use_cnt got=%0d exp=%0d", stall_cnt, 4'(s0 + 1));
    end
    advance();
  endtask

  task automatic test_redirect();
    int f0;
    set_idle();
    ex_is_load = 1; ex_wr = 1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1; ex_redirect = 1;
    f0 = m_flush_cnt;
    sample();
    checks++;
    if ({flush_id, bubble_ex, stall_if, stall_id} !== 4'b1100) begin
      errors++; $display("FAIL redirect_prio got=%b exp=1100", {flush_id, bubble_ex, stall_if, stall_id});
    end
    checks++;
    if (obs_vec() !== e_vec) begin errors++; $display("FAIL redirect_model got=%h exp=%h", obs_vec(), e_vec); end
    advance();
    set_idle();
    sample();
    checks++;
    if (flush_cnt !== 4'(f0 + 1)) begin
      errors++; $display("FAIL redirect_cnt got=%0d exp=%0d", flush_cnt, 4'(f0 + 1));
    end
    advance();
  endtask

  task automatic test_dmem_wait();
    int s0;
    set_idle();
    dmem_req = 1;
    s0 = m_stall_cnt;
    for (int i = 0; i < 3; i++) begin
      sample();
      checks++;
      if ({stall_if, stall_id, stall_ex, stall_mem} !== 4'b1111) begin
        errors++; $display("FAIL dmem_wait_stall cyc=%0d got=%b exp=1111", i, {stall_if, stall_id, stall_ex, stall_mem});
      end
      advance();
    end
    dmem_ack = 1;
    sample();
    checks++;
    if ({stall_if, stall_id, stall_ex, stall_mem} !== 4'b0000) begin
      errors++; $display("FAIL dmem_ack_release got=%b exp=0000", {stall_if, stall_id, stall_ex, stall_mem});
    end
    advance();
    set_idle();
    ex_redirect = 1;
    sample();
    checks++;
    if (flush_id !== 1'b1) begin errors++; $display("FAIL dmem_back_in_run got=%b exp=1", flush_id); end
    checks++;
    if (stall_cnt !== 4'(s0 + 3)) begin
      errors++; $display("FAIL dmem_stall_cnt got=%0d exp=%0d", stall_cnt, 4'(s0 + 3));
    end
    advance();
  endtask

  task automatic test_timeout();
    test_reset();
    dmem_req = 1;
    for (int i = 0; i < 1 + TIMEOUT; i++) begin
      sample();
      checks++;
      if (obs_vec() !== e_vec) begin errors++; $display("FAIL timeout_model cyc=%0d got=%h exp=%h", i, obs_vec(), e_vec); end
      advance();
    end
    dmem_ack = 1; ex_redirect = 1;
    sample();
    checks++;
    if ({err, stall_if, stall_id, stall_ex, stall_mem, flush_id} !== 6'b111110) begin
      errors++; $display("FAIL timeout_err_sticky got=%b exp=111110", {err, stall_if, stall_id, stall_ex, stall_mem, flush_id});
    end
    advance();
    rst = 1'b0;
    #1;
    checks++;
    if ({stall_if, stall_id, stall_ex, stall_mem, flush_id, bubble_ex, err, stall_cnt, flush_cnt} !== 15'd0) begin
      errors++; $display("FAIL timeout_async_reset got=%h exp=0", obs_vec());
    end
    m_reset();
    sample();
    advance();
    rst = 1'b1;
    set_idle();
    sample();
    checks++;
    if (obs_vec() !== e_vec) begin errors++; $display("FAIL timeout_after_reset got=%h exp=%h", obs_vec(), e_vec); end
    advance();
  endtask

  task automatic test_forward();
    set_idle();
    mem_rd = 5'd7; wb_rd = 5'd7; ex_rs1 = 5'd7; mem_wr = 1; wb_wr = 1;
    sample();
    checks++;
    if (fwd_a !== 2'b01) begin errors++; $display("FAIL fwd_mem_prio got=%b exp=01", fwd_a); end
    advance();
    mem_wr = 0; ex_rs2 = 5'd7;
    sample();
    checks++;
    if ({fwd_a, fwd_b} !== 4'b1010) begin errors++; $display("FAIL fwd_wb got=%b exp=1010", {fwd_a, fwd_b}); end
    advance();
    mem_rd = 5'd0; wb_rd = 5'd0; ex_rs1 = 5'd0; ex_rs2 = 5'd0; mem_wr = 1; wb_wr = 1;
    sample();
    checks++;
    if ({fwd_a, fwd_b} !== 4'b0000) begin errors++; $display("FAIL fwd_x0 got=%b exp=0000", {fwd_a, fwd_b}); end
    advance();
  endtask

  task automatic test_counter_wrap();
    test_reset();
    ex_is_load = 1; ex_wr = 1; ex_rd = 5'd3; id_rs2 = 5'd3; id_use_rs2 = 1;
    for (int i = 0; i < 16; i++) begin
      sample();
      checks++;
      if (obs_vec() !== e_vec) begin errors++; $display("FAIL wrap_model cyc=%0d got=%h exp=%h", i, obs_vec(), e_vec); end
      advance();
    end
    set_idle();
    sample();
    checks++;
    if (stall_cnt !== 4'd0) begin errors++; $display("FAIL wrap_to_zero got=%0d exp=0", stall_cnt); end
    advance();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      if (m_error && $urandom_range(0, 7) == 0) begin
        rst = 1'b0;
        #1;
        m_reset();
      end
      sample();
      checks++;
      if (obs_vec() !== e_vec) begin errors++; $display("FAIL random cyc=%0d got=%h exp=%h", i, obs_vec(), e_vec); end
      advance();
      rst = 1'b1;
    end
    set_idle();
  endtask

  initial begin
    set_idle();
    rst = 1'b0;
    m_reset();
    #12;
    test_reset();
    test_load_use();
    test_redirect();
    test_dmem_wait();
    test_forward();
    test_timeout();
    test_counter_wrap();
    test_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning max dmem wait cycles before error.
REQ-002 SHALL have parameter CNT_W, default 32, meaning perf counter width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports id_rs1, id_rs2  input  5 each  source registers of ID-stage instruction.
REQ-006 SHALL have ports id_use_rs1, id_use_rs2  input  1 each  ID instruction reads that source.
REQ-007 SHALL have ports ex_rs1, ex_rs2  input  5 each  source registers of EX-stage instruction.
REQ-008 SHALL have ports ex_rd, mem_rd, wb_rd  input  5 each  destination registers per stage.
REQ-009 SHALL have ports ex_wr, mem_wr, wb_wr  input  1 each  stage writes register file.
REQ-010 SHALL have port ex_is_load  input  1  EX instruction is a load.
REQ-011 SHALL have port ex_redirect  input  1  taken branch/jump resolved in EX.
REQ-012 SHALL have ports dmem_req, dmem_ack  input  1 each  MEM-stage access request / completion.
REQ-013 SHALL have ports stall_if, stall_id, stall_ex, stall_mem  output  1 each  hold PC / respective pipeline register.
REQ-014 SHALL have ports flush_id, bubble_ex  output  1 each  zero IF/ID / insert NOP into ID/EX.
REQ-015 SHALL have ports fwd_a, fwd_b  output  2 each  operand select: 00 regfile, 01 MEM, 10 WB.
REQ-016 SHALL have ports stall_cnt, flush_cnt  output  CNT_W each  performance counters.
REQ-017 SHALL have port err  output  1  sticky dmem timeout flag.

Function
REQ-018 SHALL implement FSM states RUN, MWAIT, ERR; outputs Mealy on state and inputs, zero latency.
REQ-019 SHALL, in RUN with dmem_req=1 and dmem_ack=0, assert all four stall_* that cycle and go to MWAIT.
REQ-020 SHALL, in MWAIT, assert all stall_* while dmem_ack=0; on dmem_ack=1 deassert all stalls that cycle and return to RUN.
REQ-021 SHALL count MWAIT cycles in a wait counter cleared on entry to MWAIT; on reaching TIMEOUT with dmem_ack=0 go to ERR.
REQ-022 SHALL, in ERR, hold all stall_* and err at 1 until reset; ex_redirect and dmem_ack ignored.
REQ-023 SHALL, in RUN without freeze and ex_redirect=1, assert flush_id and bubble_ex for that cycle, no stalls.
REQ-024 SHALL detect load-use when ex_is_load & ex_wr & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
REQ-025 SHALL, on load-use in RUN without freeze or redirect, assert stall_if, stall_id, bubble_ex for exactly that cycle.
REQ-026 SHALL apply priority freeze (REQ-019/020/022) > redirect > load-use; lower-priority outputs suppressed.
REQ-027 SHALL set fwd_a=01 if mem_wr & mem_rd!=0 & mem_rd==ex_rs1, else 10 if wb_wr & wb_rd!=0 & wb_rd==ex_rs1, else 00; fwd_b same on ex_rs2.
REQ-028 SHALL never forward or stall on register x0.
REQ-029 SHALL increment stall_cnt each cycle any stall_* is 1, and flush_cnt each cycle flush_id is 1.
REQ-030 SHALL let both counters wrap modulo 2^CNT_W without flag.

Reset
REQ-031 SHALL, on rst=0 (async, any state including MWAIT/ERR), force state RUN, wait counter 0, stall_cnt 0, flush_cnt 0, err 0.
REQ-032 SHALL hold all stall_*, flush_id, bubble_ex at 0 while rst=0; fwd_a/fwd_b stay combinational.

Structure
REQ-033 SHALL place FSM state encodings and fwd select codes (FWD_RF, FWD_MEM, FWD_WB) in shared package rv32i_pkg.
REQ-034 SHALL instantiate sub-module fwd_sel twice (operand A, B), each combinational from stage rd/wr and one ex_rs.

Verification
REQ-035 SHALL check: ex_is_load=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> one cycle stall_if=stall_id=bubble_ex=1, stall_cnt +1.
REQ-036 SHALL check: load-use plus ex_redirect=1 same cycle -> flush_id=bubble_ex=1, stall_if=0, flush_cnt +1.
REQ-037 SHALL check: dmem_req=1, ack after 3 cycles -> stalls high 3 cycles, low on ack cycle, state RUN, stall_cnt +3.
REQ-038 SHALL check: TIMEOUT=4, dmem_ack held 0 -> ERR, err=1, stalls stuck high; rst pulse -> all outputs/counters 0.
REQ-039 SHALL check: mem_rd=wb_rd=ex_rs1=7, both wr=1 -> fwd_a=01; mem_rd=0, wb_rd=0, ex_rs1=0 -> fwd_a=00.
REQ-040 SHALL check: CNT_W=4, 16 stall cycles from 0 -> stall_cnt wraps to 0.
